tag_table_ctrl: RTL
===================

# tag_table_ctrl

Sequencing controller for a tag table of `VEC_SIZE` entries searched by the parallel tag matcher. It accepts lookup, allocate, invalidate and flush commands over a valid/ready handshake and drives the matcher with a registered tag. It owns the tag storage, valid bits and round-robin replacement pointer, and returns hit/index/evict results over a second handshake. It sits between the prefetcher stream logic and the table it indexes.

## Interface
- `LOG_VEC_SIZE`, 6: log2 of entry count.
- `VEC_SIZE`, `1<<LOG_VEC_SIZE`: entry count (derived; not overridden).
- `TAG_SIZE`, 64: tag width in bits.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  controller can accept a command.
- `req_op`  in  2  00 LOOKUP, 01 ALLOC, 10 INVAL, 11 FLUSH.
- `req_tag`  in  TAG_SIZE  tag operand (ignored for FLUSH).
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_hit`  out  1  tag was present before the command.
- `rsp_idx`  out  LOG_VEC_SIZE  matched or allocated entry index.
- `rsp_evict`  out  1  ALLOC overwrote a valid entry.
- `valid_vec`  out  VEC_SIZE  current valid bits.
- `occupancy`  out  LOG_VEC_SIZE+1  count of valid entries, 0..VEC_SIZE.
- `full`  out  1  `occupancy == VEC_SIZE`.

## Operation
- FSM states: IDLE, MATCH, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_op` and `req_tag`, go to MATCH.
- MATCH: matcher evaluates the latched tag against the stored tags and `valid_vec`. Apply the update, register the response, go to RESP.
- RESP: `rsp_valid`=1 and response fields stable. On `rsp_ready`, return to IDLE. Otherwise hold.
- LOOKUP: no table change. Hit gives `rsp_hit`=1 and `rsp_idx`=match. Miss gives `rsp_hit`=0 and `rsp_idx`=0.
- ALLOC on hit: no change; `rsp_hit`=1, `rsp_idx`=match. Duplicate tags are therefore never created.
- ALLOC on miss, not full: write the tag into the lowest-index invalid entry and set its valid bit. `rsp_idx`=that entry, `rsp_evict`=0.
- ALLOC on miss, full: overwrite the entry at the victim pointer. `rsp_idx`=victim, `rsp_evict`=1. The pointer then increments modulo VEC_SIZE (VEC_SIZE-1 wraps to 0).
- The victim pointer changes only on eviction.
- INVAL on hit: clear that valid bit; `rsp_hit`=1, `rsp_idx`=match. INVAL on miss: no change, `rsp_hit`=0.
- FLUSH: clear all valid bits; `rsp_hit`=0, `rsp_idx`=0, `rsp_evict`=0. The victim pointer is unchanged.
- `rsp_evict`=0 for every op other than ALLOC.
- `occupancy` is maintained by counter: +1 on non-evicting ALLOC miss, -1 on INVAL hit, 0 on FLUSH. It must always equal popcount(`valid_vec`).

## Timing
- Command accepted at edge N (IDLE, `req_valid`&`req_ready`).
- Table update and response registered at edge N+1.
- `rsp_valid` is high from cycle N+2 until the edge where `rsp_ready`=1.
- Minimum issue interval is 3 cycles. Only one command is outstanding.
- `req_ready` is low in MATCH and RESP. No request-to-ready combinational path.
- `valid_vec`, `occupancy` and `full` reflect the update from edge N+1 onward.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_hit`=0, `rsp_idx`=0, `rsp_evict`=0, `valid_vec`=0, `occupancy`=0, `full`=0, victim pointer 0.
- Tag storage is not reset.
- `rst` during MATCH or RESP: the pending command and response are discarded and the table is cleared at that edge.
- `rst` has priority over every other event.

## Structure
- Shared package holds:
  - op enum `tag_op_e` (LOOKUP/ALLOC/INVAL/FLUSH);
  - FSM state enum;
  - response struct (hit, idx, evict).
- Single sub-module: the existing matcher `findValueIdx`, instantiated once on the latched tag, stored tags and `valid_vec`.
- The lowest-free-entry priority encoder and the occupancy counter are local logic.

## Test plan
All scenarios use LOG_VEC_SIZE=2, TAG_SIZE=8.
- Reset, then LOOKUP 0x12 -> `rsp_valid` at cycle N+2, `rsp_hit`=0, `rsp_idx`=0, `occupancy`=0.
- ALLOC 0x10, 0x11, 0x12, 0x13 -> `rsp_idx` 0,1,2,3, `rsp_evict`=0, `full`=1 after the fourth. Then ALLOC 0x11 -> `rsp_hit`=1, `rsp_idx`=1, no change.
- Full table, ALLOC 0x20 then 0x21 -> `rsp_idx`=0 then 1, `rsp_evict`=1. Then LOOKUP 0x10 -> miss.
- INVAL 0x12 -> `rsp_hit`=1, `rsp_idx`=2, `occupancy`=3. Then ALLOC 0x30 -> `rsp_idx`=2, `rsp_evict`=0.
- Hold `rsp_ready`=0 for 5 cycles -> response stable, `req_ready`=0 throughout. FLUSH -> `valid_vec`=0, `occupancy`=0.
- Assert `rst` in MATCH of an ALLOC -> next cycle `rsp_valid`=0, `valid_vec`=0, state IDLE.

Source files
------------

// File: rtl/tag_table_ctrl_pkg.sv
// Shared types for the tag table controller: command opcodes, FSM states
// and the registered response record.
package tag_table_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_ALLOC  = 2'b01,
    OP_INVAL  = 2'b10,
    OP_FLUSH  = 2'b11
  } tag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_RESP  = 2'd2
  } tag_state_e;

  // Index field sized for the largest supported table; the top keeps the low bits.
  localparam int RSP_IDX_W = 16;

  typedef struct packed {
    logic                 hit;
    logic [RSP_IDX_W-1:0] idx;
    logic                 evict;
  } tag_rsp_t;

endpackage

// File: rtl/tag_table_ctrl_find.sv
// Parallel tag matcher: compares one value against every valid stored tag
// and reports whether it is present and, if so, the lowest matching index.
module findValueIdx #(
  parameter  int LOG_VEC_SIZE = 6,
  parameter  int TAG_SIZE     = 64,
  localparam int VEC_SIZE     = 1 << LOG_VEC_SIZE
) (
  input  logic [TAG_SIZE-1:0]               value,
  input  logic [VEC_SIZE-1:0][TAG_SIZE-1:0] vec,
  input  logic [VEC_SIZE-1:0]               vec_valid,
  output logic                              found,
  output logic [LOG_VEC_SIZE-1:0]           idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (vec_valid[i] && (vec[i] == value)) begin
        found = 1'b1;
        idx   = LOG_VEC_SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/tag_table_ctrl.sv
// Tag table sequencer: accepts one command at a time, resolves it against the
// stored tags in a single MATCH cycle and holds the result until consumed.
module tag_table_ctrl
  import tag_table_ctrl_pkg::*;
#(
  parameter  int LOG_VEC_SIZE = 6,
  parameter  int TAG_SIZE     = 64,
  localparam int VEC_SIZE     = 1 << LOG_VEC_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [TAG_SIZE-1:0]     req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output logic [LOG_VEC_SIZE-1:0] rsp_idx,
  output logic                    rsp_evict,
  output logic [VEC_SIZE-1:0]     valid_vec,
  output logic [LOG_VEC_SIZE:0]   occupancy,
  output logic                    full
);

  localparam logic [LOG_VEC_SIZE:0] FULL_CNT = (LOG_VEC_SIZE + 1)'(VEC_SIZE);

  tag_state_e                        state_q, state_d;
  tag_op_e                           op_q, op_d;
  logic [TAG_SIZE-1:0]               tag_q, tag_d;
  logic [VEC_SIZE-1:0][TAG_SIZE-1:0] tags_q;
  logic [VEC_SIZE-1:0]               valid_q, valid_d;
  logic [LOG_VEC_SIZE:0]             occ_q, occ_d;
  logic [LOG_VEC_SIZE-1:0]           victim_q, victim_d;
  tag_rsp_t                          rsp_q, rsp_d;

  logic                    wr_en;
  logic [LOG_VEC_SIZE-1:0] wr_idx;
  logic                    m_hit;
  logic [LOG_VEC_SIZE-1:0] m_idx;
  logic [LOG_VEC_SIZE-1:0] free_idx;
  logic                    table_full;

  function automatic logic [LOG_VEC_SIZE-1:0] lowest_free(input logic [VEC_SIZE-1:0] v);
    logic [LOG_VEC_SIZE-1:0] r;
    r = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (!v[i]) r = LOG_VEC_SIZE'(i);
    end
    return r;
  endfunction

  findValueIdx #(
    .LOG_VEC_SIZE (LOG_VEC_SIZE),
    .TAG_SIZE     (TAG_SIZE)
  ) u_find (
    .value     (tag_q),
    .vec       (tags_q),
    .vec_valid (valid_q),
    .found     (m_hit),
    .idx       (m_idx)
  );

  assign free_idx   = lowest_free(valid_q);
  assign table_full = (occ_q == FULL_CNT);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    valid_d  = valid_q;
    occ_d    = occ_q;
    victim_d = victim_q;
    rsp_d    = rsp_q;
    wr_en    = 1'b0;
    wr_idx   = free_idx;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = tag_op_e'(req_op);
          tag_d   = req_tag;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        state_d   = ST_RESP;
        rsp_d.hit   = m_hit && (op_q != OP_FLUSH);
        rsp_d.idx   = rsp_d.hit ? RSP_IDX_W'(m_idx) : '0;
        rsp_d.evict = 1'b0;
        case (op_q)
          OP_ALLOC: begin
            // A hit leaves the table alone so a tag is never stored twice.
            if (!m_hit) begin
              wr_en = 1'b1;
              if (!table_full) begin
                wr_idx           = free_idx;
                valid_d[free_idx] = 1'b1;
                occ_d            = occ_q + 1'b1;
                rsp_d.idx        = RSP_IDX_W'(free_idx);
              end else begin
                wr_idx      = victim_q;
                victim_d    = victim_q + 1'b1;
                rsp_d.idx   = RSP_IDX_W'(victim_q);
                rsp_d.evict = 1'b1;
              end
            end
          end
          OP_INVAL: begin
            if (m_hit) begin
              valid_d[m_idx] = 1'b0;
              occ_d          = occ_q - 1'b1;
            end
          end
          OP_FLUSH: begin
            valid_d = '0;
            occ_d   = '0;
          end
          default: ;
        endcase
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      occ_q    <= '0;
      victim_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      occ_q    <= occ_d;
      victim_q <= victim_d;
      rsp_q    <= rsp_d;
    end
  end

  // Operand latch and tag storage carry data only and are left unreset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    tag_q <= tag_d;
    if (wr_en && !rst) tags_q[wr_idx] <= tag_q;
  end

  logic unused_rsp_idx;
  assign unused_rsp_idx = ^rsp_q.idx;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hit   = rsp_q.hit;
  assign rsp_idx   = rsp_q.idx[LOG_VEC_SIZE-1:0];
  assign rsp_evict = rsp_q.evict;
  assign valid_vec = valid_q;
  assign occupancy = occ_q;
  assign full      = table_full;

endmodule
